pcw_boot_sequencer: RTL and testbench
=====================================

# pcw_boot_sequencer

Sequences the reset-time boot-ROM reload of the PCW core. After each reset release it copies a small boot ROM into guest RAM at address 0 through the core's download port, then optionally reads it back and checks it. On success it pulses the execute strobe so the CPU starts at the loaded code. It sits between the boot ROM and the core's `dn_*`/`execute_*` inputs, clocked by `clk_sys` and paced by the SDRAM reference tick.

## Interface
Parameters:
- `ROM_LEN`, 276: bytes to copy (addresses 0..ROM_LEN-1), range 2..65536.
- `ADDR_W`, 16: width of address outputs.
- `MAX_RETRY`, 3: full write+verify attempts before failure (verify build only).

Ports:
- `clk_sys`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse, begins or restarts the sequence.
- `ref_tick`  in  1: SDRAM reference (CPU ce) level; rising edge paces steps.
- `sdram_ready`  in  1: SDRAM initialised; steps are gated by it.
- `rom_addr`  out  ADDR_W: boot ROM read address (asynchronous ROM).
- `rom_data`  in  8: boot ROM byte at `rom_addr`.
- `dn_go`  out  1: download window active.
- `dn_wr`  out  1: write strobe to guest RAM.
- `dn_rd`  out  1: read strobe from guest RAM.
- `dn_addr`  out  ADDR_W: guest RAM address.
- `dn_data`  out  8: write data.
- `rd_data`  in  8: readback data, valid when the step after `dn_rd` occurs.
- `execute_enable`  out  1: start-execution strobe.
- `execute_addr`  out  ADDR_W: constant 0.
- `busy`  out  1: sequence in progress.
- `done`  out  1: sticky success, cleared by `start`.
- `error`  out  1: sticky verify failure, cleared by `start`.

## Operation
- Step: `step = sdram_ready & ref_tick & ~ref_q`. `ref_q` is `ref_tick` registered every cycle. All state changes below occur only on clock edges with `step=1`, except `start` and `reset`.
- One address counter drives both `rom_addr` and `dn_addr` (always equal).
- States: IDLE, WR_LOAD, WR_HOLD, RD_REQ, RD_CHK, EXEC, EXEC_HOLD, DONE, FAIL.
- `start` (any state):
  - counter←0, retry←0, `dn_go`←1, `busy`←1.
  - `done`/`error`/`dn_wr`/`dn_rd`/`execute_enable`←0.
  - → WR_LOAD.
- WR_LOAD: `dn_data`←`rom_data`, `dn_wr`←1 → WR_HOLD.
- WR_HOLD: `dn_wr`←0.
  - If counter==ROM_LEN-1: counter←0 → RD_REQ (verify) or EXEC.
  - Else counter+1 → WR_LOAD.
- RD_REQ: `dn_rd`←1 → RD_CHK.
- RD_CHK: `dn_rd`←0. Compare `rd_data` with `rom_data`.
  - Match, last address → EXEC.
  - Match, not last → counter+1, → RD_REQ.
  - Mismatch, retry+1<MAX_RETRY → retry+1, counter←0, → WR_LOAD.
  - Mismatch, otherwise → FAIL.
- EXEC: `execute_enable`←1 → EXEC_HOLD.
- EXEC_HOLD: `execute_enable`←0, `dn_go`←0, `busy`←0, `done`←1 → DONE.
- FAIL (entry): `dn_go`←0, `busy`←0, `error`←1. `execute_enable` never asserts.
- DONE/FAIL hold until `start`.
- Counter never exceeds ROM_LEN-1.

## Timing
- Reset values: all outputs 0, state IDLE, `ref_q` 0. Reset mid-sequence aborts immediately; strobes drop asynchronously.
- Each strobe is high for exactly one step period.
- Latency start→`done`, no verify: 2·ROM_LEN+2 steps. With clean verify: 4·ROM_LEN+2 steps, each step being one `ref_tick` period (16 `clk_sys` at a /16 ce).
- `sdram_ready` low freezes the sequence with outputs held.
- `start` coincident with `step`: `start` wins.
- `ref_tick` held high produces only one step.

## Configuration
- `PCW_BOOT_VERIFY_EN` defined: RD_REQ/RD_CHK and retry logic are present, and `error` is functional.
- Undefined: WR_HOLD last address → EXEC directly. `dn_rd` and `error` are tied 0, `rd_data` is unused, and `MAX_RETRY` is ignored.

## Structure
- Package `pcw_boot_pkg`: state enum `boot_state_t`, default `ROM_LEN`/`ADDR_W` constants.
- Sub-module `boot_step_det`: registers `ref_tick` and outputs gated rising-edge `step`.
- Main FSM and counters live in `pcw_boot_sequencer`.

## Test plan
- Reset, ROM_LEN=4, ROM {AA,55,01,FF}, `ref_tick` period 16, ready=1, `start` → four `dn_wr` pulses at addr 0..3 with matching data; `done`=1 after 2·4+2 steps (verify off) or 4·4+2 steps (verify on); `execute_enable` high exactly one step.
- Verify on, readback byte 2 returns 00 once → single retry: second full write pass, then `done`=1, `error`=0.
- Verify on, persistent mismatch at addr 0, MAX_RETRY=3 → three write passes, `error`=1, `dn_go`=0, no `execute_enable`.
- `sdram_ready` low for 100 cycles during WR_HOLD → outputs frozen; resumes with no skipped or duplicated address.
- `start` during RD_REQ at addr 2 → counter 0, `dn_rd`=0, new WR_LOAD; async `reset` mid-write → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/pcw_boot_pkg.sv
// Shared state encoding and default sizing for the PCW boot-ROM reload sequencer.
package pcw_boot_pkg;

  localparam int DEF_ROM_LEN   = 276;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_LOAD,
    S_WR_HOLD,
    S_RD_REQ,
    S_RD_CHK,
    S_EXEC,
    S_EXEC_HOLD,
    S_DONE,
    S_FAIL
  } boot_state_t;

endpackage

// File: rtl/boot_step_det.sv
// Step pacing: one-cycle pulse on each rising edge of the SDRAM reference tick,
// suppressed while the SDRAM is not yet initialised.
module boot_step_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ref_tick,
  input  logic i_ready,
  output logic o_step
);

  logic r_ref_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ref_q <= 1'b0;
    else       r_ref_q <= i_ref_tick;
  end

  assign o_step = i_ready & i_ref_tick & ~r_ref_q;

endmodule

// File: rtl/pcw_boot_sequencer.sv
// Reloads the boot ROM into guest RAM at address 0 after reset, then strobes execute.
// Define PCW_BOOT_VERIFY_EN to add readback verification with bounded retries.
module pcw_boot_sequencer
  import pcw_boot_pkg::*;
#(
  parameter int ROM_LEN   = DEF_ROM_LEN,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              ref_tick,
  input  logic              sdram_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              dn_go,
  output logic              dn_wr,
  output logic              dn_rd,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  input  logic [7:0]        rd_data,
  output logic              execute_enable,
  output logic [ADDR_W-1:0] execute_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_LEN - 1);

  logic w_step;

  boot_step_det u_step (
    .i_clk      (clk_sys),
    .i_rst      (reset),
    .i_ref_tick (ref_tick),
    .i_ready    (sdram_ready),
    .o_step     (w_step)
  );

  boot_state_t       r_state, w_state;
  logic [ADDR_W-1:0] r_cnt, w_cnt;
  logic [7:0]        r_data, w_data;
  logic              r_go, w_go, r_wr, w_wr, r_exec, w_exec;
  logic              r_busy, w_busy, r_done, w_done;

`ifdef PCW_BOOT_VERIFY_EN
  localparam int RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  logic [RTY_W-1:0]  r_retry, w_retry;
  logic              r_rd, w_rd, r_err, w_err;
`endif

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_data  = r_data;
    w_go    = r_go;
    w_wr    = r_wr;
    w_exec  = r_exec;
    w_busy  = r_busy;
    w_done  = r_done;
`ifdef PCW_BOOT_VERIFY_EN
    w_retry = r_retry;
    w_rd    = r_rd;
    w_err   = r_err;
`endif
    // A restart request overrides any step landing on the same edge.
    if (start) begin
      w_state = S_WR_LOAD;
      w_cnt   = '0;
      w_go    = 1'b1;
      w_busy  = 1'b1;
      w_wr    = 1'b0;
      w_exec  = 1'b0;
      w_done  = 1'b0;
`ifdef PCW_BOOT_VERIFY_EN
      w_retry = '0;
      w_rd    = 1'b0;
      w_err   = 1'b0;
`endif
    end else if (w_step) begin
      case (r_state)
        S_WR_LOAD: begin
          w_data  = rom_data;
          w_wr    = 1'b1;
          w_state = S_WR_HOLD;
        end
        S_WR_HOLD: begin
          w_wr = 1'b0;
          if (r_cnt == LAST) begin
            w_cnt = '0;
`ifdef PCW_BOOT_VERIFY_EN
            w_state = S_RD_REQ;
`else
            w_state = S_EXEC;
`endif
          end else begin
            w_cnt   = r_cnt + 1'b1;
            w_state = S_WR_LOAD;
          end
        end
`ifdef PCW_BOOT_VERIFY_EN
        S_RD_REQ: begin
          w_rd    = 1'b1;
          w_state = S_RD_CHK;
        end
        S_RD_CHK: begin
          w_rd = 1'b0;
          if (rd_data == rom_data) begin
            if (r_cnt == LAST) begin
              w_state = S_EXEC;
            end else begin
              w_cnt   = r_cnt + 1'b1;
              w_state = S_RD_REQ;
            end
          end else if ((32'(r_retry) + 32'd1) < 32'(MAX_RETRY)) begin
            w_retry = r_retry + 1'b1;
            w_cnt   = '0;
            w_state = S_WR_LOAD;
          end else begin
            w_go    = 1'b0;
            w_busy  = 1'b0;
            w_err   = 1'b1;
            w_state = S_FAIL;
          end
        end
`endif
        S_EXEC: begin
          w_exec  = 1'b1;
          w_state = S_EXEC_HOLD;
        end
        S_EXEC_HOLD: begin
          w_exec  = 1'b0;
          w_go    = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_go    <= 1'b0;
      r_wr    <= 1'b0;
      r_exec  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PCW_BOOT_VERIFY_EN
      r_retry <= '0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
      r_go    <= w_go;
      r_wr    <= w_wr;
      r_exec  <= w_exec;
      r_busy  <= w_busy;
      r_done  <= w_done;
`ifdef PCW_BOOT_VERIFY_EN
      r_retry <= w_retry;
      r_rd    <= w_rd;
      r_err   <= w_err;
`endif
    end
  end

`ifdef PCW_BOOT_VERIFY_EN
  assign dn_rd = r_rd;
  assign error = r_err;
`else
  logic w_unused;
  assign w_unused = ^{rd_data, (MAX_RETRY > 0)};
  assign dn_rd    = 1'b0;
  assign error    = 1'b0;
`endif

  assign rom_addr       = r_cnt;
  assign dn_addr        = r_cnt;
  assign dn_data        = r_data;
  assign dn_go          = r_go;
  assign dn_wr          = r_wr;
  assign execute_enable = r_exec;
  assign execute_addr   = '0;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_pcw_boot_sequencer.sv
// Randomized bench for pcw_boot_sequencer against a pass-level model of the reload sequence.
`timescale 1ns/1ps
module tb_pcw_boot_sequencer;

  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int MAXR = 3;
`ifdef PCW_BOOT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          ref_tick = 1'b0;
  logic          sdram_ready = 1'b1;
  logic [AW-1:0] rom_addr, dn_addr, execute_addr;
  logic [7:0]    rom_data, dn_data;
  logic [7:0]    rd_data = 8'h00;
  logic          dn_go, dn_wr, dn_rd, execute_enable, busy, done, error;

  logic [7:0] rom [0:N-1];
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_err    = 0;
  int ph       = 0;
  int steps    = 0;
  logic ref_prev = 1'b0;

  int         wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int rd_cnt, exec_pulses, exec_cycles, done_step, err_step;
  int bad_addr = -1;
  int bad_left = 0;
  bit bad_persist = 1'b0;
  logic p_wr = 1'b0, p_rd = 1'b0, p_ex = 1'b0, p_done = 1'b0, p_err = 1'b0;

  pcw_boot_sequencer #(.ROM_LEN(N), .ADDR_W(AW), .MAX_RETRY(MAXR)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .start          (start),
    .ref_tick       (ref_tick),
    .sdram_ready    (sdram_ready),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .dn_go          (dn_go),
    .dn_wr          (dn_wr),
    .dn_rd          (dn_rd),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .rd_data        (rd_data),
    .execute_enable (execute_enable),
    .execute_addr   (execute_addr),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  assign rom_data = (rom_addr < AW'(N)) ? rom[rom_addr[1:0]] : 8'h00;

  always #5 clk_sys = ~clk_sys;

  // Reference tick: 16-cycle period, high for 8 cycles.
  initial forever begin
    @(negedge clk_sys);
    ph = (ph + 1) % 16;
    ref_tick = (ph < 8);
  end

  // Independent step count since the last start.
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ref_prev <= 1'b0;
    end else begin
      if (start) steps <= 0;
      else if (sdram_ready && ref_tick && !ref_prev) steps <= steps + 1;
      ref_prev <= ref_tick;
    end
  end

  // Transaction monitor and guest RAM model with readback fault injection.
  initial forever begin
    @(negedge clk_sys);
    if (dn_wr && !p_wr) begin
      wr_addr_q.push_back(int'(dn_addr));
      wr_data_q.push_back(dn_data);
      mem[dn_addr[7:0]] = dn_data;
    end
    if (dn_rd && !p_rd) begin
      rd_cnt++;
      rd_data = mem[dn_addr[7:0]];
      if (int'(dn_addr) == bad_addr && bad_left > 0) begin
        bad_left--;
        rd_data = bad_persist ? ~mem[dn_addr[7:0]] : 8'h00;
      end
    end
    if (execute_enable) exec_cycles++;
    if (execute_enable && !p_ex) exec_pulses++;
    if (done && !p_done) done_step = steps;
    if (error && !p_err) err_step = steps;
    p_wr = dn_wr; p_rd = dn_rd; p_ex = execute_enable; p_done = done; p_err = error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk_sys);
    #1 start = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cnt = 0; exec_pulses = 0; exec_cycles = 0;
    done_step = -1; err_step = -1;
  endtask

  // Pass-level model: each write pass costs two steps per byte; verification
  // reads back byte by byte (two steps each) until the first mismatch.
  task automatic model(input int bad_a, input int bad_t, output int exp_steps,
                       output int exp_wr, output int exp_rd, output bit exp_ok);
    int left;
    int fail_at;
    left = bad_t;
    exp_steps = 0; exp_wr = 0; exp_rd = 0; exp_ok = 1'b0;
    for (int pass = 0; pass < (VERIFY ? MAXR : 1); pass++) begin
      fail_at = -1;
      exp_wr += N;
      exp_steps += 2 * N;
      if (VERIFY) begin
        for (int a = 0; a < N; a++) begin
          exp_rd++;
          exp_steps += 2;
          if (a == bad_a && left > 0) begin
            left--;
            fail_at = a;
            break;
          end
        end
      end
      if (fail_at < 0) begin
        exp_steps += 2;
        exp_ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_case(input string tag, input int bad_a, input int bad_t, input bit persist,
                          input bit coincide, input bit freeze, input bit restart);
    int es, ew, er;
    bit eok;
    bit froze, restarted;
    logic [31:0] snap;
    int guard;
    model(restart ? -1 : bad_a, restart ? 0 : bad_t, es, ew, er, eok);
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom);
    if (rom[2] == 8'h00) rom[2] = 8'h5A;
    tick();
    clear_mon();
    bad_addr = restart ? -1 : bad_a;
    bad_left = restart ? 0 : bad_t;
    bad_persist = persist;
    if (coincide) begin
      guard = 0;
      while (ph != 0 && guard < 40) begin tick(); guard++; end
    end else begin
      repeat ($urandom_range(0, 15)) tick();
    end
    pulse_start();
    tick();
    check({tag, "_busy_on"}, {30'd0, busy, dn_go}, 32'h3);
    froze = 1'b0;
    restarted = 1'b0;
    guard = 0;
    while (!(done || error) && guard < 3000) begin
      if (freeze && !froze && wr_addr_q.size() == 2 && dn_wr) begin
        froze = 1'b1;
        sdram_ready = 1'b0;
        snap = {1'b0, dn_go, dn_wr, dn_rd, busy, done, error, execute_enable, dn_addr, dn_data};
        repeat (100) tick();
        check({tag, "_frozen"}, {1'b0, dn_go, dn_wr, dn_rd, busy, done, error, execute_enable, dn_addr, dn_data}, snap);
        check({tag, "_frozen_wr"}, wr_addr_q.size(), 2);
        sdram_ready = 1'b1;
      end
      if (restart && !restarted &&
          (VERIFY ? (rd_cnt == 2 && !dn_rd && dn_addr == 16'd2) : (dn_wr && dn_addr == 16'd2))) begin
        restarted = 1'b1;
        clear_mon();
        pulse_start();
        tick();
        check({tag, "_rs_addr"}, dn_addr, 0);
        check({tag, "_rs_strobes"}, {29'd0, dn_rd, dn_wr, dn_go}, 32'h1);
        check({tag, "_rs_busy"}, busy, 1);
      end
      tick();
      guard++;
    end
    if (guard >= 3000) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    repeat (40) tick();
    check({tag, "_done"}, done, eok);
    check({tag, "_error"}, error, VERIFY ? !eok : 1'b0);
    check({tag, "_idle"}, {30'd0, busy, dn_go}, 0);
    check({tag, "_steps"}, eok ? done_step : err_step, es);
    check({tag, "_nwr"}, wr_addr_q.size(), ew);
    check({tag, "_nrd"}, rd_cnt, VERIFY ? er : 0);
    check({tag, "_exec_pulses"}, exec_pulses, eok ? 1 : 0);
    check({tag, "_exec_cycles"}, exec_cycles, eok ? 16 : 0);
    check({tag, "_exec_addr"}, execute_addr, 0);
    for (int i = 0; i < wr_addr_q.size() && i < ew; i++) begin
      check({tag, "_wr_addr"}, wr_addr_q[i], i % N);
      check({tag, "_wr_data"}, wr_data_q[i], rom[i % N]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < N; i++) rom[i] = 8'h00;
    clear_mon();
    repeat (3) tick();
    check("reset_ctl", {25'd0, dn_go, dn_wr, dn_rd, execute_enable, busy, done, error}, 0);
    check("reset_addr", {dn_addr, rom_addr}, 0);
    check("reset_data", {dn_data, execute_addr}, 0);
    reset = 1'b0;
    repeat (40) tick();
    check("idle_no_start", {30'd0, busy, dn_go}, 0);

    run_case("clean_coinc", -1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_case("clean_rand",  -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case("freeze",      -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_case("retry_once",   2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case("persist_fail", 0, 99, 1'b1, 1'b0, 1'b0, 1'b0);
    run_case("restart",     -1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      run_case("random", int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write pass.
    tick();
    clear_mon();
    pulse_start();
    begin
      int guard;
      guard = 0;
      while (!dn_wr && guard < 500) begin tick(); guard++; end
      check("arst_reached_wr", dn_wr, 1);
    end
    #3 reset = 1'b1;
    #1;
    check("arst_ctl", {25'd0, dn_go, dn_wr, dn_rd, execute_enable, busy, done, error}, 0);
    check("arst_addr_data", {dn_data, dn_addr}, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (40) tick();
    check("arst_stays_idle", {29'd0, busy, dn_go, dn_wr}, 0);

    run_case("after_arst", -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
